// File: rtl/lc3_gated_bus.sv
// LC-3 gated datapath bus: registered N-source arbiter with contention count.
// Optional LC3_BUS_RR_EN selects round-robin instead of fixed priority.
module lc3_gated_bus #(
  parameter int              WIDTH     = 16,
  parameter int              N_SRC     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 8,
  localparam int             SEL_W     = $clog2(N_SRC)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic [N_SRC-1:0]       i_Gate,
  input  logic [N_SRC*WIDTH-1:0] i_Src_Data,
  input  logic                   i_Hold,
  input  logic                   i_Clr_Cnt,
  output logic [WIDTH-1:0]       o_Bus,
  output logic                   o_Bus_Valid,
  output logic [SEL_W-1:0]       o_Sel,
  output logic                   o_Contention,
  output logic [CNT_W-1:0]       o_Contention_Cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    FROZEN
  } state_t;

  state_t           state;
  logic             frz_valid;
  logic [N_SRC-1:0] rot;
  logic             any_gate;
  logic             multi;
  logic             found;
  int               off;
  logic [SEL_W-1:0] win;
  logic [WIDTH-1:0] win_data;

  assign any_gate = |i_Gate;
  assign multi    = (i_Gate & (i_Gate - N_SRC'(1))) != '0;

`ifdef LC3_BUS_RR_EN
  logic [SEL_W-1:0] ptr;

  // Rotate requests so the pointer position becomes bit 0.
  assign rot = N_SRC'({i_Gate, i_Gate} >> ptr);
`else
  assign rot = i_Gate;
`endif

  // First asserted request in rotated order, mapped back to a source index.
  always_comb begin
    found = 1'b0;
    off   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
`ifdef LC3_BUS_RR_EN
    win = SEL_W'((int'(ptr) + off) % N_SRC);
`else
    win = SEL_W'(off);
`endif
  end

  // Index-compare mux keeps X on unselected sources off the bus.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (SEL_W'(k) == win)
        win_data = i_Src_Data[k*WIDTH +: WIDTH];
    end
  end

  // Valid survives a freeze through the snapshot taken on entry.
  assign o_Bus_Valid = (state == DRIVE) ||
                       ((state == FROZEN) && frz_valid);

  // Bus FSM, registered outputs and saturating contention counter.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state            <= IDLE;
      frz_valid        <= 1'b0;
      o_Bus            <= RESET_VAL;
      o_Sel            <= '0;
      o_Contention     <= 1'b0;
      o_Contention_Cnt <= '0;
`ifdef LC3_BUS_RR_EN
      ptr              <= '0;
`endif
    end else if (i_Hold) begin
      state        <= FROZEN;
      frz_valid    <= o_Bus_Valid;
      o_Contention <= 1'b0;
    end else begin
      o_Contention <= multi;
      if (i_Clr_Cnt)
        o_Contention_Cnt <= '0;
      else if (multi && (o_Contention_Cnt != '1))
        o_Contention_Cnt <= o_Contention_Cnt + CNT_W'(1);
      if (any_gate) begin
        state <= DRIVE;
        o_Bus <= win_data;
        o_Sel <= win;
`ifdef LC3_BUS_RR_EN
        ptr   <= SEL_W'((int'(win) + 1) % N_SRC);
`endif
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
